// File: rtl/cache_access_arbiter.sv
// cache_access_arbiter
//
// Shares the cache lookup path between an instruction requester (port 0) and
// a data requester (port 1). One transaction at a time, round-robin when both
// ports request. Each transaction strobes the cache, samples the 2-bit hit
// code LOOKUP_LAT cycles later, and on a double miss runs a main-memory fetch
// handshake bounded by MEM_TIMEOUT cycles before pulsing Done.
//
// Parameters:
//   LOOKUP_LAT  (1..7)    cycles from CStrobe to a valid CHit
//   MEM_TIMEOUT (2..255)  max cycles in the memory fetch before giving up
//   ADDWID                address width
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   Req0/Add0           port 0 request (held until Done0) and address
//   Req1/Add1           port 1 request (held until Done1) and address
//   Done0/Done1         one-cycle completion pulses
//   Result              01 L1 hit, 10 L2 hit, 00 memory fill, 11 timeout
//   CAdd/CStrobe/CHit   cache lookup address, strobe, returned hit code
//   MemReq/MemAdd/MemAck main-memory fetch handshake
//
// Optional feature (macro CACHE_ARB_STATS_EN): adds StatClr input and the
// saturating 16-bit outcome counters L1Cnt, L2Cnt, MissCnt, ErrCnt.

module cache_access_arbiter #(
  parameter int LOOKUP_LAT  = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int ADDWID      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic [ADDWID-1:0] Add0,
  input  logic              Req1,
  input  logic [ADDWID-1:0] Add1,
  output logic              Done0,
  output logic              Done1,
  output logic [1:0]        Result,
  output logic [ADDWID-1:0] CAdd,
  output logic              CStrobe,
  input  logic [1:0]        CHit,
  output logic              MemReq,
  output logic [ADDWID-1:0] MemAdd,
  input  logic              MemAck
`ifdef CACHE_ARB_STATS_EN
  ,
  input  logic              StatClr,
  output logic [15:0]       L1Cnt,
  output logic [15:0]       L2Cnt,
  output logic [15:0]       MissCnt,
  output logic [15:0]       ErrCnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STROBE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_MEM    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(LOOKUP_LAT - 1);
  localparam logic [7:0] TO_LOAD   = 8'(MEM_TIMEOUT);

  state_t              state_q, state_d;
  logic                cur_q, cur_d;     // port owning the current transaction
  logic                last_q, last_d;   // port granted most recently
  logic [ADDWID-1:0]   cadd_q, cadd_d;
  logic [ADDWID-1:0]   madd_q, madd_d;
  logic [1:0]          result_q, result_d;
  logic [2:0]          wcnt_q, wcnt_d;   // lookup latency countdown
  logic [7:0]          tcnt_q, tcnt_d;   // memory timeout countdown
  logic                pick;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= 1'b0;
      last_q   <= 1'b1;   // so port 0 wins the first tie after reset
      cadd_q   <= '0;
      madd_q   <= '0;
      result_q <= 2'b00;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      cadd_q   <= cadd_d;
      madd_q   <= madd_d;
      result_q <= result_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    cadd_d   = cadd_q;
    madd_d   = madd_q;
    result_d = result_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    // On a tie take the port that did not go last; otherwise whoever asks.
    pick     = (Req0 && Req1) ? ~last_q : Req1;

    case (state_q)
      ST_IDLE: begin
        if (Req0 || Req1) begin
          cur_d   = pick;
          cadd_d  = pick ? Add1 : Add0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        wcnt_d  = WAIT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == 3'd0) begin
          if (CHit == 2'b01 || CHit == 2'b10) begin
            result_d = CHit;
            state_d  = ST_DONE;
          end else begin
            // 00 and the illegal 11 both go to memory.
            madd_d  = cadd_q;
            tcnt_d  = TO_LOAD;
            state_d = ST_MEM;
          end
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ST_MEM: begin
        if (MemAck) begin
          result_d = 2'b00;
          state_d  = ST_DONE;
        end else begin
          tcnt_d = tcnt_q - 8'd1;
          // Exiting when the count hits 0 gives exactly MEM_TIMEOUT MEM cycles.
          if (tcnt_q == 8'd1) begin
            result_d = 2'b11;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        last_d  = cur_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and pulses decode straight from state so reset drops them at once.
  assign CStrobe = (state_q == ST_STROBE);
  assign MemReq  = (state_q == ST_MEM);
  assign Done0   = (state_q == ST_DONE) && !cur_q;
  assign Done1   = (state_q == ST_DONE) &&  cur_q;
  assign Result  = result_q;
  assign CAdd    = cadd_q;
  assign MemAdd  = madd_q;

`ifdef CACHE_ARB_STATS_EN
  // Indexed directly by the Result code: 0 fill, 1 L1, 2 L2, 3 timeout.
  logic [3:0][15:0] stat_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stat_q <= '0;
    end else if (StatClr) begin
      stat_q <= '0;
    end else if (state_q == ST_DONE && stat_q[result_q] != 16'hFFFF) begin
      stat_q[result_q] <= stat_q[result_q] + 16'd1;
    end
  end

  assign MissCnt = stat_q[0];
  assign L1Cnt   = stat_q[1];
  assign L2Cnt   = stat_q[2];
  assign ErrCnt  = stat_q[3];
`endif

endmodule
